// File: rtl/ias_fetch_unit.sv
// IAS instruction fetch stage: reads 40-bit words at PC, issues the left half and
// buffers the right half in the IBR so memory is read once per instruction pair.
module ias_fetch_unit #(
  parameter int ADDR_W = 12,
  parameter int WORD_W = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              jump_right,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [7:0]        opcode,
  output logic [ADDR_W-1:0] operand_addr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy
);

  localparam int HALF_W = WORD_W / 2;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] ISSUE = 2'd3;
  localparam logic [ADDR_W-1:0] PC_INC = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_r, state_s;
  logic [ADDR_W-1:0] pc_r, pc_s;
  logic [HALF_W-1:0] ibr_r, ibr_s;
  logic              ibr_valid_r, ibr_valid_s;
  logic              start_right_r, start_right_s;
  logic              discard_r, discard_s;
  logic [7:0]        opcode_r, opcode_s;
  logic [ADDR_W-1:0] operand_addr_r, operand_addr_s;
  logic              instr_valid_r, instr_valid_s;
  logic              mem_rd_r, mem_rd_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic              busy_r, busy_s;

  // Next-state and next-output computation; a jump overrides PC/IBR state last.
  always_comb begin
    state_s        = state_r;
    pc_s           = pc_r;
    ibr_s          = ibr_r;
    ibr_valid_s    = ibr_valid_r;
    start_right_s  = start_right_r;
    discard_s      = discard_r;
    opcode_s       = opcode_r;
    operand_addr_s = operand_addr_r;
    instr_valid_s  = 1'b0;
    mem_rd_s       = 1'b0;
    mem_addr_s     = mem_addr_r;

    case (state_r)
      IDLE: begin
        if (fetch_req && !jump_valid) begin
          if (ibr_valid_r) begin
            opcode_s       = ibr_r[HALF_W-1 -: 8];
            operand_addr_s = ibr_r[ADDR_W-1:0];
            ibr_valid_s    = 1'b0;
            pc_s           = pc_r + PC_INC;
            instr_valid_s  = 1'b1;
            state_s        = ISSUE;
          end else begin
            mem_rd_s   = 1'b1;
            mem_addr_s = pc_r;
            state_s    = REQ;
          end
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        state_s = WAIT;
        if (jump_valid) begin
          discard_s = 1'b1;
        end else begin
          discard_s = discard_r;
        end
      end
      WAIT: begin
        // A jump coinciding with the returning data drops that data too.
        if (mem_rvalid) begin
          if (discard_r || jump_valid) begin
            discard_s = 1'b0;
            state_s   = IDLE;
          end else if (start_right_r) begin
            opcode_s       = mem_rdata[HALF_W-1 -: 8];
            operand_addr_s = mem_rdata[ADDR_W-1:0];
            start_right_s  = 1'b0;
            pc_s           = pc_r + PC_INC;
            instr_valid_s  = 1'b1;
            state_s        = ISSUE;
          end else begin
            opcode_s       = mem_rdata[WORD_W-1 -: 8];
            operand_addr_s = mem_rdata[WORD_W-9 -: ADDR_W];
            ibr_s          = mem_rdata[HALF_W-1:0];
            ibr_valid_s    = 1'b1;
            instr_valid_s  = 1'b1;
            state_s        = ISSUE;
          end
        end else if (jump_valid) begin
          discard_s = 1'b1;
        end else begin
          state_s = WAIT;
        end
      end
      ISSUE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    if (jump_valid) begin
      pc_s          = jump_addr;
      ibr_valid_s   = 1'b0;
      start_right_s = jump_right;
    end else begin
      start_right_s = start_right_s;
    end

    busy_s = (state_s != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= IDLE;
      pc_r           <= '0;
      ibr_r          <= '0;
      ibr_valid_r    <= 1'b0;
      start_right_r  <= 1'b0;
      discard_r      <= 1'b0;
      opcode_r       <= 8'h00;
      operand_addr_r <= '0;
      instr_valid_r  <= 1'b0;
      mem_rd_r       <= 1'b0;
      mem_addr_r     <= '0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      pc_r           <= pc_s;
      ibr_r          <= ibr_s;
      ibr_valid_r    <= ibr_valid_s;
      start_right_r  <= start_right_s;
      discard_r      <= discard_s;
      opcode_r       <= opcode_s;
      operand_addr_r <= operand_addr_s;
      instr_valid_r  <= instr_valid_s;
      mem_rd_r       <= mem_rd_s;
      mem_addr_r     <= mem_addr_s;
      busy_r         <= busy_s;
    end
  end

  assign mem_addr     = mem_addr_r;
  assign mem_rd       = mem_rd_r;
  assign opcode       = opcode_r;
  assign operand_addr = operand_addr_r;
  assign instr_valid  = instr_valid_r;
  assign pc_out       = pc_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_ias_fetch_unit.sv
// Directed bench for ias_fetch_unit: table of fetch/jump transactions against a
// latency-configurable memory model, plus hand sequences for timing, jump-in-WAIT and reset.
module tb_ias_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req, jump_valid, jump_right;
  logic [11:0] jump_addr;
  logic [11:0] mem_addr;
  logic        mem_rd;
  logic [39:0] mem_rdata;
  logic        mem_rvalid;
  logic [7:0]  opcode;
  logic [11:0] operand_addr;
  logic        instr_valid;
  logic [11:0] pc_out;
  logic        busy;

  ias_fetch_unit #(.ADDR_W(12), .WORD_W(40)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .jump_valid(jump_valid),
    .jump_addr(jump_addr), .jump_right(jump_right), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .opcode(opcode), .operand_addr(operand_addr), .instr_valid(instr_valid),
    .pc_out(pc_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory model: data returns lat cycles after the strobe; not cleared by DUT reset.
  logic [39:0] mem [0:4095];
  int          lat;
  int          cnt;
  logic [11:0] pend_addr;
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = 40'h0;
    cnt        = 0;
    pend_addr  = 12'h000;
  end
  always @(posedge clk) begin
    mem_rvalid <= 1'b0;
    if (mem_rd) begin
      pend_addr <= mem_addr;
      if (lat <= 1) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= mem[mem_addr];
      end else begin
        cnt <= lat - 1;
      end
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= mem[pend_addr];
      end
    end
  end

  // Event counters observed on the falling edge.
  int          n_rd = 0;
  int          n_iv = 0;
  logic [11:0] last_rd_addr = 12'h000;
  always @(negedge clk) begin
    if (mem_rd) begin
      n_rd = n_rd + 1;
      last_rd_addr = mem_addr;
    end
    if (instr_valid) n_iv = n_iv + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        fetch;
    logic        jump;
    logic        jright;
    logic [11:0] jaddr;
    int          exp_iv;
    logic [7:0]  exp_op;
    logic [11:0] exp_addr;
    logic [11:0] exp_pc;
    int          exp_rd;
    logic [11:0] exp_rdaddr;
  } vec_t;

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    chk({tag, "_idle_timeout"}, busy, 1'b0);
    repeat (6) @(negedge clk);
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int base_rd, base_iv;
    @(negedge clk);
    base_rd = n_rd;
    base_iv = n_iv;
    fetch_req  = v.fetch;
    jump_valid = v.jump;
    jump_addr  = v.jaddr;
    jump_right = v.jright;
    @(negedge clk);
    fetch_req  = 1'b0;
    jump_valid = 1'b0;
    jump_right = 1'b0;
    wait_idle(tag);
    chk({tag, "_issues"}, n_iv - base_iv, v.exp_iv);
    chk({tag, "_opcode"}, opcode, v.exp_op);
    chk({tag, "_operand"}, operand_addr, v.exp_addr);
    chk({tag, "_pc"}, pc_out, v.exp_pc);
    chk({tag, "_reads"}, n_rd - base_rd, v.exp_rd);
    if (v.exp_rd > 0) chk({tag, "_rdaddr"}, last_rd_addr, v.exp_rdaddr);
  endtask

  vec_t vecs [10];
  vec_t v;
  int   base_rd, base_iv;

  initial begin
    // fetch, jump, jright, jaddr, issues, opcode, operand, pc, reads, read address
    vecs[0] = '{1'b1, 1'b0, 1'b0, 12'h000, 1, 8'h01, 12'h005, 12'h000, 1, 12'h000};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 12'h000, 1, 8'h03, 12'h006, 12'h001, 0, 12'h000};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 12'h000, 1, 8'h0A, 12'h111, 12'h001, 1, 12'h001};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 12'h010, 0, 8'h0A, 12'h111, 12'h010, 0, 12'h000};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 12'h000, 1, 8'h06, 12'h0BB, 12'h011, 1, 12'h010};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 12'h000, 1, 8'h07, 12'h0CC, 12'h011, 1, 12'h011};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 12'hFFF, 0, 8'h07, 12'h0CC, 12'hFFF, 0, 12'h000};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 12'h000, 1, 8'h0E, 12'h555, 12'hFFF, 1, 12'hFFF};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 12'h000, 1, 8'h0F, 12'h666, 12'h000, 0, 12'h000};
    vecs[9] = '{1'b1, 1'b0, 1'b0, 12'h000, 1, 8'h01, 12'h005, 12'h000, 1, 12'h000};

    for (int i = 0; i < 4096; i++) mem[i] = 40'h0;
    mem[12'h000] = 40'h01_005_03_006;
    mem[12'h001] = 40'h0A_111_0B_222;
    mem[12'h010] = 40'h05_0AA_06_0BB;
    mem[12'h011] = 40'h07_0CC_08_0DD;
    mem[12'h020] = 40'h0C_333_0D_444;
    mem[12'hFFF] = 40'h0E_555_0F_666;

    lat = 1;
    reset = 1'b1;
    fetch_req = 1'b0;
    jump_valid = 1'b0;
    jump_right = 1'b0;
    jump_addr = 12'h000;
    #3;
    chk("rst_opcode", opcode, 8'h00);
    chk("rst_operand", operand_addr, 12'h000);
    chk("rst_iv", instr_valid, 1'b0);
    chk("rst_rd", mem_rd, 1'b0);
    chk("rst_maddr", mem_addr, 12'h000);
    chk("rst_pc", pc_out, 12'h000);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      run_txn(v, $sformatf("vec%0d", i));
    end

    // Timing: IBR hit issues the next cycle, best-case miss after three.
    @(negedge clk);
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    chk("hit_iv", instr_valid, 1'b1);
    chk("hit_busy", busy, 1'b1);
    chk("hit_rd", mem_rd, 1'b0);
    chk("hit_opcode", opcode, 8'h03);
    @(negedge clk);
    chk("hit_iv_pulse", instr_valid, 1'b0);
    chk("hit_busy_end", busy, 1'b0);
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    chk("miss_rd", mem_rd, 1'b1);
    chk("miss_maddr", mem_addr, 12'h001);
    chk("miss_iv_c1", instr_valid, 1'b0);
    @(negedge clk);
    chk("miss_rd_pulse", mem_rd, 1'b0);
    chk("miss_maddr_hold", mem_addr, 12'h001);
    chk("miss_iv_c2", instr_valid, 1'b0);
    @(negedge clk);
    chk("miss_iv_c3", instr_valid, 1'b1);
    chk("miss_opcode", opcode, 8'h0A);
    chk("miss_operand", operand_addr, 12'h111);
    @(negedge clk);
    chk("miss_busy_end", busy, 1'b0);

    // Jump while a read of 0x000 is pending: data dropped, next fetch reads 0x020.
    v = '{1'b0, 1'b1, 1'b0, 12'h000, 0, 8'h0A, 12'h111, 12'h000, 0, 12'h000};
    run_txn(v, "jw_setup");
    lat = 4;
    @(negedge clk);
    base_rd = n_rd;
    base_iv = n_iv;
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk);
    chk("jw_in_wait", busy & ~mem_rd, 1'b1);
    jump_valid = 1'b1;
    jump_addr  = 12'h020;
    @(negedge clk);
    jump_valid = 1'b0;
    wait_idle("jw");
    chk("jw_no_issue", n_iv - base_iv, 0);
    chk("jw_reads", n_rd - base_rd, 1);
    chk("jw_pc", pc_out, 12'h020);
    v = '{1'b1, 1'b0, 1'b0, 12'h000, 1, 8'h0C, 12'h333, 12'h020, 1, 12'h020};
    run_txn(v, "jw_next");

    // Reset in the middle of WAIT, then the stale data arrives in IDLE.
    v = '{1'b0, 1'b1, 1'b0, 12'h001, 0, 8'h0C, 12'h333, 12'h001, 0, 12'h000};
    run_txn(v, "rw_setup");
    @(negedge clk);
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk);
    chk("rw_in_wait", busy & ~mem_rd, 1'b1);
    base_iv = n_iv;
    reset = 1'b1;
    #1;
    chk("rw_opcode", opcode, 8'h00);
    chk("rw_operand", operand_addr, 12'h000);
    chk("rw_iv", instr_valid, 1'b0);
    chk("rw_rd", mem_rd, 1'b0);
    chk("rw_maddr", mem_addr, 12'h000);
    chk("rw_pc", pc_out, 12'h000);
    chk("rw_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("rw_stale_ignored", n_iv - base_iv, 0);
    chk("rw_busy_after", busy, 1'b0);
    chk("rw_pc_after", pc_out, 12'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
